// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM pipeline stage. Registers the EX op and runs the
//            data-memory req/ack handshake, with an ack timeout. It places
//            store data on the correct byte lanes and extracts and extends
//            load data. It also resolves branch/jump redirects for IF.
// Ports    : clk, rst_n (async, active low)
//            EX side  : in_valid/in_ready, flush, mem_wr, mem_to_reg, dsize,
//                       loadext, reg_wr, branch, zero, jump, rw, exec_result,
//                       bus_b, branch_target
//            Memory   : dm_req, dm_we, dm_addr, dm_be, dm_wdata, dm_ack,
//                       dm_rdata
//            WB side  : wb_valid, wb_reg_wr, wb_mem_to_reg, wb_rw, wb_result
//            IF side  : pc_src, pc_target
//            Status   : bus_err
// Config   : MEM_MISALIGN_CHK_EN - when defined, a misaligned half or word
//            access is rejected with bus_err instead of being issued with
//            its low address bits ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int ADDR_W   = 32,   // 3..32; taken from the low bits of exec_result
  parameter int RW_W     = 5,
  parameter int ACK_TOUT = 16    // >= 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              mem_wr,
  input  logic              mem_to_reg,
  input  logic [1:0]        dsize,
  input  logic              loadext,
  input  logic              reg_wr,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic [RW_W-1:0]   rw,
  input  logic [31:0]       exec_result,
  input  logic [31:0]       bus_b,
  input  logic [31:0]       branch_target,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic              wb_reg_wr,
  output logic              wb_mem_to_reg,
  output logic [RW_W-1:0]   wb_rw,
  output logic [31:0]       wb_result,
  output logic              pc_src,
  output logic [31:0]       pc_target,
  output logic              bus_err
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

  localparam int                 c_CNT_W    = (ACK_TOUT > 1) ? $clog2(ACK_TOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TOUT - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [c_CNT_W-1:0] r_cnt;

  // Context of the access in flight
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_loadExt;
  logic        r_isLoad;
  logic        r_killed;
  logic [31:0] r_execRes;

  logic              w_accept;
  logic              w_anyMem;
  logic              w_memOp;
  logic              w_rsvdMem;
  logic              w_misalign;
  logic              w_timeout;
  logic              w_kill;
  logic              w_takeBranch;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_stBe;
  logic [31:0]       w_stData;
  logic [7:0]        w_ldByte;
  logic [15:0]       w_ldHalf;
  logic [31:0]       w_loadData;

  assign w_accept     = in_valid & in_ready & ~flush;
  assign w_anyMem     = mem_wr | mem_to_reg;
  assign w_memOp      = w_anyMem & (dsize != 2'b10);
  assign w_rsvdMem    = w_anyMem & (dsize == 2'b10);
  assign w_takeBranch = (branch & zero) | jump;
  assign w_addr       = {exec_result[ADDR_W-1:2], 2'b00};

`ifdef MEM_MISALIGN_CHK_EN
  assign w_misalign = w_anyMem &
                      (((dsize == 2'b01) & exec_result[0]) |
                       ((dsize == 2'b11) & (exec_result[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Ack on the final allowed cycle is a normal completion, not a timeout.
  assign w_timeout = (r_state == c_ACCESS) & ~dm_ack & (r_cnt == c_CNT_LAST);
  // A flush in the completing cycle still suppresses the writeback.
  assign w_kill    = r_killed | flush;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_nextState;
  end

  // ---------------- FSM: next state ----------------
  // Non-memory, reserved-size and rejected ops complete with a registered
  // writeback pulse while the FSM stays in IDLE, so back-to-back issue works.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:   if (w_accept & w_memOp & ~w_misalign) w_nextState = c_ACCESS;
      c_ACCESS: if (dm_ack)         w_nextState = c_DONE;
                else if (w_timeout) w_nextState = c_IDLE;
      c_DONE:   w_nextState = c_IDLE;
      default:  w_nextState = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = (r_state == c_IDLE);
    dm_req   = (r_state == c_ACCESS);
  end

  // Access-cycle counter for the ack timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (r_state == c_ACCESS)  r_cnt <= r_cnt + c_CNT_W'(1);
    else                           r_cnt <= '0;
  end

  // Store lane placement
  always_comb begin
    w_stBe   = 4'b1111;
    w_stData = bus_b;
    case (dsize)
      2'b00: begin
        w_stBe   = 4'b0001 << exec_result[1:0];
        w_stData = {4{bus_b[7:0]}};
      end
      2'b01: begin
        w_stBe   = exec_result[1] ? 4'b1100 : 4'b0011;
        w_stData = {2{bus_b[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    w_ldByte = dm_rdata[{r_lane, 3'b000} +: 8];
    w_ldHalf = r_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (r_size)
      2'b00:   w_loadData = {{24{r_loadExt & w_ldByte[7]}}, w_ldByte};
      2'b01:   w_loadData = {{16{r_loadExt & w_ldHalf[15]}}, w_ldHalf};
      default: w_loadData = dm_rdata;
    endcase
  end

  // Datapath registers and one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_be         <= 4'b0000;
      dm_wdata      <= 32'd0;
      wb_valid      <= 1'b0;
      wb_reg_wr     <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rw         <= '0;
      wb_result     <= 32'd0;
      pc_src        <= 1'b0;
      pc_target     <= 32'd0;
      bus_err       <= 1'b0;
      r_size        <= 2'b00;
      r_lane        <= 2'b00;
      r_loadExt     <= 1'b0;
      r_isLoad      <= 1'b0;
      r_killed      <= 1'b0;
      r_execRes     <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      pc_src   <= 1'b0;
      bus_err  <= 1'b0;

      if (w_accept) begin
        wb_rw         <= rw;
        wb_mem_to_reg <= mem_to_reg;
        pc_src        <= w_takeBranch;
        if (w_takeBranch) pc_target <= branch_target;

        if (w_misalign) begin
          wb_valid  <= 1'b1;
          wb_reg_wr <= 1'b0;
          wb_result <= 32'd0;
          bus_err   <= 1'b1;
        end else if (w_memOp) begin
          dm_we     <= mem_wr;
          dm_addr   <= w_addr;
          dm_be     <= w_stBe;
          dm_wdata  <= w_stData;
          r_size    <= dsize;
          r_lane    <= exec_result[1:0];
          r_loadExt <= loadext;
          r_isLoad  <= mem_to_reg & ~mem_wr;
          r_execRes <= exec_result;
          r_killed  <= 1'b0;
          wb_reg_wr <= reg_wr & ~mem_wr;
        end else begin
          wb_valid  <= 1'b1;
          wb_reg_wr <= reg_wr;
          wb_result <= w_rsvdMem ? 32'd0 : exec_result;
        end
      end

      if (r_state == c_ACCESS) begin
        if (flush) r_killed <= 1'b1;
        if (dm_ack) begin
          wb_valid  <= ~w_kill;
          wb_result <= r_isLoad ? w_loadData : r_execRes;
        end else if (w_timeout) begin
          wb_valid  <= ~w_kill;
          bus_err   <= ~w_kill;
          wb_reg_wr <= 1'b0;
          wb_result <= 32'd0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Directed self-checking bench for mem_stage_ctrl. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Config   : MEM_MISALIGN_CHK_EN selects the expected misaligned behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  localparam int ADDR_W   = 32;
  localparam int RW_W     = 5;
  localparam int ACK_TOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, flush, mem_wr, mem_to_reg, loadext, reg_wr;
  logic [1:0]        dsize;
  logic              branch, zero, jump;
  logic [RW_W-1:0]   rw;
  logic [31:0]       exec_result, bus_b, branch_target;
  logic              dm_req, dm_we, dm_ack;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata, dm_rdata;
  logic              wb_valid, wb_reg_wr, wb_mem_to_reg;
  logic [RW_W-1:0]   wb_rw;
  logic [31:0]       wb_result, pc_target;
  logic              pc_src, bus_err;

  int nChecks = 0;
  int nErrors = 0;

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .RW_W(RW_W), .ACK_TOUT(ACK_TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .dsize(dsize), .loadext(loadext),
    .reg_wr(reg_wr), .branch(branch), .zero(zero), .jump(jump), .rw(rw),
    .exec_result(exec_result), .bus_b(bus_b), .branch_target(branch_target),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rw(wb_rw), .wb_result(wb_result), .pc_src(pc_src), .pc_target(pc_target),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clearOp();
    in_valid = 0; flush = 0; mem_wr = 0; mem_to_reg = 0; dsize = 2'b11; loadext = 0;
    reg_wr = 0; branch = 0; zero = 0; jump = 0; rw = '0;
    exec_result = 0; bus_b = 0; branch_target = 0;
  endtask

  // Presents the op for one cycle; returns at the negedge of cycle N+1.
  task automatic issue();
    in_valid = 1;
    step();
    in_valid = 0;
  endtask

  // Acks in the current cycle; returns at the negedge of the following cycle.
  task automatic ackNow(input logic [31:0] data);
    dm_ack = 1; dm_rdata = data;
    step();
    dm_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqCnt, errCnt, wbCnt, wbWrSeen;
    clearOp();
    dm_ack = 0; dm_rdata = 0; rst_n = 0;
    repeat (2) step();
    checkVal("rst in_ready", in_ready, 1);
    checkVal("rst dm_req", dm_req, 0);
    checkVal("rst wb_valid", wb_valid, 0);
    checkVal("rst pc_src", pc_src, 0);
    checkVal("rst bus_err", bus_err, 0);
    checkVal("rst wb_result", wb_result, 0);
    rst_n = 1;
    step();

    // Non-memory ops, back to back
    reg_wr = 1; rw = 7; exec_result = 32'h1234;
    in_valid = 1;
    step();
    checkVal("alu1 wb_valid", wb_valid, 1);
    checkVal("alu1 wb_result", wb_result, 32'h1234);
    checkVal("alu1 wb_reg_wr", wb_reg_wr, 1);
    checkVal("alu1 wb_rw", wb_rw, 7);
    checkVal("alu1 in_ready", in_ready, 1);
    rw = 9; exec_result = 32'h5678;
    step();
    in_valid = 0;
    checkVal("alu2 wb_valid", wb_valid, 1);
    checkVal("alu2 wb_result", wb_result, 32'h5678);
    checkVal("alu2 wb_rw", wb_rw, 9);
    step();
    checkVal("alu idle wb_valid", wb_valid, 0);

    // Branch taken / not taken
    clearOp(); branch = 1; zero = 1; branch_target = 32'h40;
    issue();
    checkVal("br pc_src", pc_src, 1);
    checkVal("br pc_target", pc_target, 32'h40);
    step();
    checkVal("br pc_src pulse", pc_src, 0);
    zero = 0;
    issue();
    checkVal("br nt pc_src", pc_src, 0);

    // Word load at 0x100, ack three cycles after request
    clearOp(); mem_to_reg = 1; reg_wr = 1; dsize = 2'b11; exec_result = 32'h100; rw = 3;
    issue();
    checkVal("ldw dm_req", dm_req, 1);
    checkVal("ldw dm_addr", dm_addr, 32'h100);
    checkVal("ldw dm_be", dm_be, 4'hF);
    checkVal("ldw dm_we", dm_we, 0);
    checkVal("ldw in_ready N+1", in_ready, 0);
    repeat (2) begin
      step();
      checkVal("ldw dm_req hold", dm_req, 1);
      checkVal("ldw in_ready hold", in_ready, 0);
    end
    step();
    checkVal("ldw in_ready M", in_ready, 0);
    ackNow(32'hDEADBEEF);
    checkVal("ldw wb_valid", wb_valid, 1);
    checkVal("ldw wb_result", wb_result, 32'hDEADBEEF);
    checkVal("ldw wb_reg_wr", wb_reg_wr, 1);
    checkVal("ldw wb_rw", wb_rw, 3);
    checkVal("ldw in_ready M+1", in_ready, 0);
    checkVal("ldw dm_req off", dm_req, 0);
    step();
    checkVal("ldw in_ready after", in_ready, 1);
    checkVal("ldw wb_valid pulse", wb_valid, 0);

    // Byte loads at lane 3, signed then unsigned
    clearOp(); mem_to_reg = 1; reg_wr = 1; dsize = 2'b00; exec_result = 32'h203; loadext = 1;
    issue();
    checkVal("ldb dm_addr", dm_addr, 32'h200);
    ackNow(32'h80123456);
    checkVal("ldb sext", wb_result, 32'hFFFFFF80);
    step();
    loadext = 0;
    issue();
    ackNow(32'h80123456);
    checkVal("ldb zext", wb_result, 32'h00000080);
    step();

    // Half load at lane 2, signed
    clearOp(); mem_to_reg = 1; reg_wr = 1; dsize = 2'b01; exec_result = 32'h202; loadext = 1;
    issue();
    ackNow(32'h80017FFF);
    checkVal("ldh sext", wb_result, 32'hFFFF8001);
    step();

    // Half store at offset 2
    clearOp(); mem_wr = 1; dsize = 2'b01; exec_result = 32'h302; bus_b = 32'h1234ABCD;
    issue();
    checkVal("sth dm_req", dm_req, 1);
    checkVal("sth dm_be", dm_be, 4'b1100);
    checkVal("sth dm_wdata", dm_wdata, 32'hABCDABCD);
    checkVal("sth dm_we", dm_we, 1);
    checkVal("sth dm_addr", dm_addr, 32'h300);
    ackNow(32'h0);
    checkVal("sth wb_valid", wb_valid, 1);
    checkVal("sth wb_reg_wr", wb_reg_wr, 0);
    step();

    // Byte store at offset 1
    clearOp(); mem_wr = 1; dsize = 2'b00; exec_result = 32'h301; bus_b = 32'h1234ABCD;
    issue();
    checkVal("stb dm_be", dm_be, 4'b0010);
    checkVal("stb dm_wdata", dm_wdata, 32'hCDCDCDCD);
    ackNow(32'h0);
    step();

    // Ack timeout
    clearOp(); mem_to_reg = 1; reg_wr = 1; dsize = 2'b11; exec_result = 32'h400;
    issue();
    reqCnt = 0; errCnt = 0; wbCnt = 0; wbWrSeen = 0;
    for (int i = 0; i < 30; i++) begin
      if (dm_req) reqCnt++;
      if (bus_err) errCnt++;
      if (wb_valid) begin
        wbCnt++;
        if (wb_reg_wr) wbWrSeen++;
      end
      step();
    end
    checkVal("tout req cycles", reqCnt, ACK_TOUT);
    checkVal("tout bus_err pulses", errCnt, 1);
    checkVal("tout wb_valid pulses", wbCnt, 1);
    checkVal("tout wb_reg_wr", wbWrSeen, 0);
    checkVal("tout in_ready", in_ready, 1);

    // Ack on the last allowed cycle wins
    issue();
    repeat (ACK_TOUT - 1) step();
    checkVal("lastack dm_req", dm_req, 1);
    ackNow(32'hCAFEF00D);
    checkVal("lastack wb_valid", wb_valid, 1);
    checkVal("lastack bus_err", bus_err, 0);
    checkVal("lastack wb_result", wb_result, 32'hCAFEF00D);
    step();

    // Flush during a pending load
    clearOp(); mem_to_reg = 1; reg_wr = 1; dsize = 2'b11; exec_result = 32'h500;
    issue();
    flush = 1;
    step();
    flush = 0;
    checkVal("flush dm_req kept", dm_req, 1);
    ackNow(32'h12345678);
    wbCnt = 0; errCnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid) wbCnt++;
      if (bus_err) errCnt++;
      step();
    end
    checkVal("flush wb_valid", wbCnt, 0);
    checkVal("flush bus_err", errCnt, 0);
    checkVal("flush in_ready", in_ready, 1);

    // Flush together with in_valid drops the op
    clearOp(); reg_wr = 1; exec_result = 32'h77; flush = 1;
    issue();
    flush = 0;
    checkVal("flush drop wb_valid", wb_valid, 0);

    // Reserved size: no access, result zero
    clearOp(); mem_to_reg = 1; reg_wr = 1; dsize = 2'b10; exec_result = 32'h55;
    issue();
    checkVal("rsvd dm_req", dm_req, 0);
    checkVal("rsvd wb_valid", wb_valid, 1);
    checkVal("rsvd wb_result", wb_result, 0);
    step();

    // Misaligned word load
    clearOp(); mem_to_reg = 1; reg_wr = 1; dsize = 2'b11; exec_result = 32'h101;
    issue();
`ifdef MEM_MISALIGN_CHK_EN
    checkVal("mis dm_req", dm_req, 0);
    checkVal("mis bus_err", bus_err, 1);
    checkVal("mis wb_valid", wb_valid, 1);
    checkVal("mis wb_reg_wr", wb_reg_wr, 0);
    step();
`else
    checkVal("mis dm_req", dm_req, 1);
    checkVal("mis dm_addr", dm_addr, 32'h100);
    checkVal("mis dm_be", dm_be, 4'hF);
    ackNow(32'h11223344);
    checkVal("mis wb_result", wb_result, 32'h11223344);
    step();
`endif

    // Reset in the middle of a handshake
    clearOp(); mem_to_reg = 1; reg_wr = 1; dsize = 2'b11; exec_result = 32'h600;
    issue();
    checkVal("rstmid dm_req before", dm_req, 1);
    #2 rst_n = 0;
    #1;
    checkVal("rstmid dm_req", dm_req, 0);
    checkVal("rstmid in_ready", in_ready, 1);
    step();
    checkVal("rstmid wb_valid", wb_valid, 0);
    checkVal("rstmid bus_err", bus_err, 0);
    rst_n = 1;
    step();

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
